jtag_tap_top: RTL and testbench
===============================

// Module: jtag_tap_top
// PURPOSE
//  Full IEEE 1149.1 TAP: 16-state controller, parametrised instruction register, and DR chains.
//  DR chains are BYPASS, IDCODE and NUM_DR user data registers; each user DR gets a capture/update port.
//  Sits between the external JTAG pins and the JTAG-to-AXI bridge logic, which consumes the user DRs.
//  Extends the bare TAP state machine with IR/DR shifting, instruction decode and TDO generation.
// PARAMETERS
//  IR_WIDTH      5             instruction register width, >= 2
//  DR_WIDTH      32            width of every user data register, >= 1
//  NUM_DR        2             number of user data registers, 1..8
//  IDCODE_VAL    32'h1000_0A5B device IDCODE; bit0 must be 1 (elaboration error otherwise)
//  IDCODE_IR     'h01          instruction selecting IDCODE
//  USER_IR_BASE  'h10          user DR i is selected by USER_IR_BASE+i; range must not hit IDCODE_IR or all-ones
// PORTS
//  tck             in   1                  JTAG clock; the only clock, all state on posedge
//  trstn           in   1                  async active-low reset
//  tms             in   1                  test mode select
//  tdi             in   1                  serial data in
//  tdo             out  1                  serial data out
//  tdo_en          out  1                  1 while in SHIFT_IR or SHIFT_DR (pad output enable)
//  tap_state       out  tap_ctrl_fsm_t     current controller state (jtag_pkg enum)
//  ir_q            out  IR_WIDTH           active (updated) instruction
//  dr_capture_data in   NUM_DR*DR_WIDTH    parallel capture values; slice i belongs to user DR i
//  dr_update_data  out  DR_WIDTH           value latched on the last user-DR UPDATE_DR
//  dr_update_valid out  NUM_DR             one-hot, 1-cycle pulse per user-DR update
// BEHAVIOUR
//  Reset (trstn=0, async): tap_state=TEST_LOGIC_RESET, ir_q=IDCODE_IR, tdo=0, tdo_en=0,
//   dr_update_data=0, dr_update_valid=0, all shift regs 0.
//  FSM, next state for tms=0 / tms=1:
//   TLR: RTI/TLR; RTI: RTI/SEL_DR; SEL_DR: CAP_DR/SEL_IR; SEL_IR: CAP_IR/TLR;
//   CAP_x: SHIFT_x/EXIT1_x; SHIFT_x: SHIFT_x/EXIT1_x; EXIT1_x: PAUSE_x/UPDATE_x;
//   PAUSE_x: PAUSE_x/EXIT2_x; EXIT2_x: SHIFT_x/UPDATE_x; UPDATE_x: RTI/SEL_DR (x = DR, IR).
//  From any state, 5 consecutive tms=1 edges reach TLR.
//  While in TLR, ir_q is synchronously reloaded to IDCODE_IR each cycle.
//  IR path:
//   Edge leaving CAPTURE_IR loads ir_sr = {0..0,2'b01}.
//   Each edge in SHIFT_IR (including the tms=1 exit edge) shifts: ir_sr = {tdi, ir_sr[IR_WIDTH-1:1]}.
//   Edge in UPDATE_IR loads ir_q = ir_sr.
//  DR decode of ir_q:
//   IDCODE_IR selects the 32-bit IDCODE DR.
//   USER_IR_BASE+i, for i < NUM_DR, selects user DR i.
//   Every other code, including all-ones, selects BYPASS.
//  DR path:
//   Capture: BYPASS loads 0; IDCODE loads IDCODE_VAL; user DR i loads slice i of dr_capture_data.
//   Shift: LSB-first, tdi enters the MSB, same edge rule as the IR path.
//   Update, user DR i only: dr_update_data = sr and dr_update_valid[i] = 1 for exactly one tck cycle.
//   BYPASS and IDCODE updates have no side effects.
//  tdo = bit0 of the selected shift register (IR in SHIFT_IR, decoded DR in SHIFT_DR); 0 otherwise.
//   tdo is a pure mux of registers, so it is glitch-free and valid for the host's next sample.
//  Latency: first captured bit appears on tdo in the cycle after entering SHIFT_x.
//   An N-bit register needs N shift edges.
//  PAUSE_x holds the shift register unchanged; a return via EXIT2 resumes shifting without recapture.
//  trstn during a shift aborts it: no update pulse, ir_q=IDCODE_IR.
//  CAPTURE immediately followed by EXIT1/UPDATE (zero shifts) updates with the captured value.
// TESTING
//  1 Reset: pulse trstn -> tap_state=TLR, ir_q=IDCODE_IR, tdo_en=0, dr_update_valid=0.
//  2 From SHIFT_DR, drive tms=1 for 5 edges -> TLR; from RTI, drive tms=1,1,1 -> TLR.
//  3 After reset, RTI->SHIFT_DR, 32 shifts -> tdo stream LSB-first equals 32'h1000_0A5B.
//  4 IR scan shifting 5'b11111 -> tdo shows 1,0,0,0,0; ir_q=all-ones after UPDATE_IR.
//    Then DR shift of tdi=1,0,1,1 -> tdo=0,1,0,1 (BYPASS, 1-cycle delay).
//  5 Load IR 'h11, capture with slice1=32'hDEAD_BEEF, shift in 32'hA5A5_0F0F, UPDATE_DR
//    -> tdo returns DEAD_BEEF LSB-first, dr_update_data=A5A5_0F0F, dr_update_valid=2'b10 for 1 cycle.
//  6 User-DR shift: go to PAUSE_DR after 16 bits, hold 10 cycles, resume -> same result as case 5.
//    Same shift: assert trstn after 16 bits -> no update pulse, TLR, ir_q=IDCODE_IR.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG definitions.
// tap_ctrl_fsm_t: the 16 IEEE 1149.1 TAP controller states, exported on the TAP's state port.
package jtag_pkg;

  typedef enum logic [3:0] {
    TestLogicReset,
    RunTestIdle,
    SelectDrScan,
    CaptureDr,
    ShiftDr,
    Exit1Dr,
    PauseDr,
    Exit2Dr,
    UpdateDr,
    SelectIrScan,
    CaptureIr,
    ShiftIr,
    Exit1Ir,
    PauseIr,
    Exit2Ir,
    UpdateIr
  } tap_ctrl_fsm_t;

endpackage

// File: rtl/jtag_tap_top.sv
// IEEE 1149.1 TAP: 16-state controller, instruction register, and BYPASS / IDCODE / user DR
// chains. The user DRs feed the JTAG-to-AXI bridge through capture/update ports.
// Ports:
//   tck_i, trstn_i        JTAG clock and async active-low reset
//   tms_i, tdi_i          test mode select, serial data in
//   tdo_o, tdo_en_o       serial data out and its pad enable (high in SHIFT_IR / SHIFT_DR)
//   tap_state_o           current controller state
//   ir_o                  active (updated) instruction
//   dr_capture_data_i     parallel capture values, slice i for user DR i
//   dr_update_data_o      value latched on the last user-DR UPDATE_DR
//   dr_update_valid_o     one-hot single-cycle pulse per user-DR update
module jtag_tap_top
  import jtag_pkg::*;
#(
  parameter int unsigned          IR_WIDTH     = 5,
  parameter int unsigned          DR_WIDTH     = 32,
  parameter int unsigned          NUM_DR       = 2,
  parameter logic [31:0]          IDCODE_VAL   = 32'h1000_0A5B,
  parameter logic [IR_WIDTH-1:0]  IDCODE_IR    = 'h01,
  parameter logic [IR_WIDTH-1:0]  USER_IR_BASE = 'h10
) (
  input  logic                       tck_i,
  input  logic                       trstn_i,
  input  logic                       tms_i,
  input  logic                       tdi_i,
  output logic                       tdo_o,
  output logic                       tdo_en_o,
  output tap_ctrl_fsm_t              tap_state_o,
  output logic [IR_WIDTH-1:0]        ir_o,
  input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture_data_i,
  output logic [DR_WIDTH-1:0]        dr_update_data_o,
  output logic [NUM_DR-1:0]          dr_update_valid_o
);

  // Elaboration-time parameter sanity checks.
  if (IDCODE_VAL[0] != 1'b1) begin : gen_idcode_chk
    $error("IDCODE_VAL bit 0 must be 1");
  end
  if (IR_WIDTH < 2 || DR_WIDTH < 1 || NUM_DR < 1 || NUM_DR > 8) begin : gen_size_chk
    $error("IR_WIDTH, DR_WIDTH or NUM_DR out of range");
  end
  for (genvar gi = 0; gi < NUM_DR; gi++) begin : gen_code_chk
    localparam logic [IR_WIDTH-1:0] Code = IR_WIDTH'(USER_IR_BASE + gi);
    if (Code == IDCODE_IR || Code == '1) begin : gen_err
      $error("user DR instruction collides with IDCODE_IR or all-ones");
    end
  end

  tap_ctrl_fsm_t         state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_sr_q;
  logic                  bypass_q;
  logic [31:0]           idcode_sr_q;
  logic [DR_WIDTH-1:0]   user_sr_q, upd_data_q, user_cap;
  logic [NUM_DR-1:0]     upd_valid_q;
  logic                  idcode_sel, user_sel;
  logic [2:0]            user_idx;

  // Instruction decode: anything that is neither IDCODE nor a user DR falls back to BYPASS.
  assign idcode_sel = (ir_q == IDCODE_IR);

  always_comb begin
    user_sel = 1'b0;
    user_idx = '0;
    for (int unsigned i = 0; i < NUM_DR; i++) begin
      if (ir_q == IR_WIDTH'(USER_IR_BASE + i)) begin
        user_sel = 1'b1;
        user_idx = 3'(i);
      end
    end
  end

  assign user_cap = dr_capture_data_i[DR_WIDTH*user_idx +: DR_WIDTH];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TestLogicReset: state_d = tms_i ? TestLogicReset : RunTestIdle;
      RunTestIdle:    state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   state_d = tms_i ? SelectIrScan   : CaptureDr;
      CaptureDr:      state_d = tms_i ? Exit1Dr        : ShiftDr;
      ShiftDr:        state_d = tms_i ? Exit1Dr        : ShiftDr;
      Exit1Dr:        state_d = tms_i ? UpdateDr       : PauseDr;
      PauseDr:        state_d = tms_i ? Exit2Dr        : PauseDr;
      Exit2Dr:        state_d = tms_i ? UpdateDr       : ShiftDr;
      UpdateDr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      SelectIrScan:   state_d = tms_i ? TestLogicReset : CaptureIr;
      CaptureIr:      state_d = tms_i ? Exit1Ir        : ShiftIr;
      ShiftIr:        state_d = tms_i ? Exit1Ir        : ShiftIr;
      Exit1Ir:        state_d = tms_i ? UpdateIr       : PauseIr;
      PauseIr:        state_d = tms_i ? Exit2Ir        : PauseIr;
      Exit2Ir:        state_d = tms_i ? UpdateIr       : ShiftIr;
      UpdateIr:       state_d = tms_i ? SelectDrScan   : RunTestIdle;
      default:        state_d = TestLogicReset;
    endcase
  end

  // Register actions are keyed on the state being left, so the exit edge of SHIFT still shifts.
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_q     <= TestLogicReset;
      ir_q        <= IDCODE_IR;
      ir_sr_q     <= '0;
      bypass_q    <= 1'b0;
      idcode_sr_q <= '0;
      user_sr_q   <= '0;
      upd_data_q  <= '0;
      upd_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      upd_valid_q <= '0;
      case (state_q)
        TestLogicReset: ir_q <= IDCODE_IR;
        CaptureIr:      ir_sr_q <= IR_WIDTH'(2'b01);
        ShiftIr:        ir_sr_q <= {tdi_i, ir_sr_q[IR_WIDTH-1:1]};
        UpdateIr:       ir_q <= ir_sr_q;
        CaptureDr: begin
          if (idcode_sel)    idcode_sr_q <= IDCODE_VAL;
          else if (user_sel) user_sr_q   <= user_cap;
          else               bypass_q    <= 1'b0;
        end
        ShiftDr: begin
          if (idcode_sel)    idcode_sr_q <= {tdi_i, idcode_sr_q[31:1]};
          else if (user_sel) user_sr_q   <= (user_sr_q >> 1) | (DR_WIDTH'(tdi_i) << (DR_WIDTH - 1));
          else               bypass_q    <= tdi_i;
        end
        UpdateDr: begin
          if (user_sel) begin
            upd_data_q  <= user_sr_q;
            upd_valid_q <= NUM_DR'(1) << user_idx;
          end
        end
        default: ;
      endcase
    end
  end

  // Pure mux of registers: stable for the whole cycle the host samples it.
  always_comb begin
    tdo_o = 1'b0;
    if (state_q == ShiftIr) begin
      tdo_o = ir_sr_q[0];
    end else if (state_q == ShiftDr) begin
      if (idcode_sel)    tdo_o = idcode_sr_q[0];
      else if (user_sel) tdo_o = user_sr_q[0];
      else               tdo_o = bypass_q;
    end
  end

  assign tdo_en_o          = (state_q == ShiftIr) || (state_q == ShiftDr);
  assign tap_state_o       = state_q;
  assign ir_o              = ir_q;
  assign dr_update_data_o  = upd_data_q;
  assign dr_update_valid_o = upd_valid_q;

endmodule

// File: tb/tb_jtag_tap_top.sv
// Self-checking bench for jtag_tap_top: directed scans plus randomized scans, all compared
// against a behavioural TAP model that tracks shift contents as plain integers.
module tb_jtag_tap_top;
  import jtag_pkg::*;

  localparam int unsigned IRW = 5;
  localparam int unsigned DRW = 32;
  localparam int unsigned NDR = 2;
  localparam logic [31:0] IDCODE = 32'h1000_0A5B;
  localparam logic [IRW-1:0] IDIR = 5'h01;

  logic tck = 1'b0;
  logic trstn, tms, tdi;
  logic tdo, tdo_en;
  tap_ctrl_fsm_t tap_state;
  logic [IRW-1:0] ir;
  logic [NDR*DRW-1:0] cap_data;
  logic [DRW-1:0] upd_data;
  logic [NDR-1:0] upd_valid;

  jtag_tap_top dut (
    .tck_i             (tck),
    .trstn_i           (trstn),
    .tms_i             (tms),
    .tdi_i             (tdi),
    .tdo_o             (tdo),
    .tdo_en_o          (tdo_en),
    .tap_state_o       (tap_state),
    .ir_o              (ir),
    .dr_capture_data_i (cap_data),
    .dr_update_data_o  (upd_data),
    .dr_update_valid_o (upd_valid)
  );

  always #5 tck = ~tck;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  tap_ctrl_fsm_t  m_state;
  logic [IRW-1:0] m_ir, m_ir_sr;
  logic [63:0]    m_dr;
  int             m_dr_len;
  logic [DRW-1:0] m_upd_data;
  logic [NDR-1:0] m_upd_valid;

  function automatic tap_ctrl_fsm_t next_state(input tap_ctrl_fsm_t s, input logic t);
    case (s)
      TestLogicReset: return t ? TestLogicReset : RunTestIdle;
      RunTestIdle:    return t ? SelectDrScan   : RunTestIdle;
      SelectDrScan:   return t ? SelectIrScan   : CaptureDr;
      SelectIrScan:   return t ? TestLogicReset : CaptureIr;
      CaptureDr, ShiftDr:  return t ? Exit1Dr : ShiftDr;
      CaptureIr, ShiftIr:  return t ? Exit1Ir : ShiftIr;
      Exit1Dr, Exit2Dr:    return t ? UpdateDr : (s == Exit1Dr ? PauseDr : ShiftDr);
      Exit1Ir, Exit2Ir:    return t ? UpdateIr : (s == Exit1Ir ? PauseIr : ShiftIr);
      PauseDr:  return t ? Exit2Dr : PauseDr;
      PauseIr:  return t ? Exit2Ir : PauseIr;
      default:  return t ? SelectDrScan : RunTestIdle;  // both UPDATE states
    endcase
  endfunction

  // -1: IDCODE, -2: BYPASS, otherwise user DR index.
  function automatic int sel_of(input logic [IRW-1:0] code);
    if (code == IDIR) return -1;
    if (int'(code) >= 16 && int'(code) < 16 + int'(NDR)) return int'(code) - 16;
    return -2;
  endfunction

  task automatic model_reset();
    m_state = TestLogicReset; m_ir = IDIR; m_ir_sr = '0;
    m_dr = '0; m_dr_len = 1; m_upd_data = '0; m_upd_valid = '0;
  endtask

  task automatic model_step(input logic t, input logic d);
    int sel;
    sel = sel_of(m_ir);
    m_upd_valid = '0;
    case (m_state)
      TestLogicReset: m_ir = IDIR;
      CaptureIr:      m_ir_sr = IRW'(1);
      ShiftIr:        m_ir_sr = (m_ir_sr >> 1) | (IRW'(d) << (IRW - 1));
      UpdateIr:       m_ir = m_ir_sr;
      CaptureDr: begin
        if (sel == -1)     begin m_dr = 64'(IDCODE); m_dr_len = 32; end
        else if (sel >= 0) begin m_dr = 64'(cap_data[sel*DRW +: DRW]); m_dr_len = DRW; end
        else               begin m_dr = '0; m_dr_len = 1; end
      end
      ShiftDr: m_dr = (m_dr >> 1) | (64'(d) << (m_dr_len - 1));
      UpdateDr: if (sel >= 0) begin
        m_upd_data = m_dr[DRW-1:0];
        m_upd_valid[sel] = 1'b1;
      end
      default: ;
    endcase
    m_state = next_state(m_state, t);
  endtask

  // ---------------- stimulus helpers ----------------
  logic           o_tdo;
  tap_ctrl_fsm_t  o_state;
  logic [IRW-1:0] o_ir;
  logic [NDR-1:0] o_valid;
  logic [DRW-1:0] o_data;

  // One TCK cycle: drive on the falling edge, compare mid-low-phase, advance model on rising edge.
  task automatic step(input logic t, input logic d);
    logic exp_tdo;
    @(negedge tck);
    tms = t; tdi = d;
    #1;
    o_tdo = tdo; o_state = tap_state; o_ir = ir; o_valid = upd_valid; o_data = upd_data;
    exp_tdo = (m_state == ShiftIr) ? m_ir_sr[0] : (m_state == ShiftDr) ? m_dr[0] : 1'b0;
    check("state", 64'(tap_state), 64'(m_state));
    check("tdo", 64'(tdo), 64'(exp_tdo));
    check("tdo_en", 64'(tdo_en), 64'(m_state == ShiftIr || m_state == ShiftDr));
    check("ir", 64'(ir), 64'(m_ir));
    check("upd_valid", 64'(upd_valid), 64'(m_upd_valid));
    check("upd_data", 64'(upd_data), 64'(m_upd_data));
    @(posedge tck);
    model_step(t, d);
  endtask

  // Async reset pulse in the middle of the low phase; TMS held high so the TAP stays in TLR.
  task automatic apply_reset();
    @(negedge tck);
    tms = 1'b1;
    trstn = 1'b0;
    #1;
    model_reset();
    check("rst_state", 64'(tap_state), 64'(TestLogicReset));
    check("rst_ir", 64'(ir), 64'(IDIR));
    check("rst_tdo_en", 64'(tdo_en), 64'd0);
    check("rst_tdo", 64'(tdo), 64'd0);
    check("rst_valid", 64'(upd_valid), 64'd0);
    #2 trstn = 1'b1;
    @(posedge tck);
    model_step(1'b1, tdi);
  endtask

  // RTI -> IR scan -> RTI, plus one idle cycle to observe the new instruction.
  task automatic ir_scan(input logic [IRW-1:0] val, output logic [IRW-1:0] bits,
                         output logic [IRW-1:0] ir_now);
    bits = '0;
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < int'(IRW); k++) begin
      step(k == int'(IRW) - 1, val[k]);
      bits[k] = o_tdo;
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    ir_now = o_ir;
  endtask

  // RTI -> DR scan of n bits (optional pause after pause_at bits) -> RTI; returns the pulse seen.
  task automatic dr_scan(input logic [63:0] data, input int n, input int pause_at,
                         input int pause_len, output logic [63:0] bits,
                         output logic [NDR-1:0] pv, output logic [DRW-1:0] pd);
    bits = '0;
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    if (n == 0) begin
      step(1'b1, 1'b0);
    end else begin
      step(1'b0, 1'b0);
      for (int k = 0; k < n; k++) begin
        logic last, brk;
        last = (k == n - 1);
        brk = !last && pause_len > 0 && k == pause_at - 1;
        step(last || brk, data[k]);
        bits[k] = o_tdo;
        if (brk) begin
          repeat (pause_len) step(1'b0, 1'b0);
          step(1'b1, 1'b0); step(1'b0, 1'b0);
        end
      end
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    pv = o_valid; pd = o_data;
  endtask

  logic [IRW-1:0] ibits, inow;
  logic [63:0]    dbits, rdata;
  logic [NDR-1:0] pv;
  logic [DRW-1:0] pd;

  initial begin
    trstn = 1'b1; tms = 1'b1; tdi = 1'b0; cap_data = '0;
    model_reset();
    apply_reset();

    // Five TMS-high edges from SHIFT_DR, three from RTI.
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("tms5_to_tlr", 64'(o_state), 64'(TestLogicReset));
    step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("rti_tms3_to_tlr", 64'(o_state), 64'(TestLogicReset));

    // IDCODE read straight after reset.
    apply_reset();
    step(1'b0, 1'b0);
    rdata = {$urandom, $urandom};
    dr_scan(rdata, 32, 0, 0, dbits, pv, pd);
    check("idcode_stream", dbits[31:0], 64'h1000_0A5B);
    check("idcode_no_pulse", 64'(pv), 64'd0);

    // All-ones instruction -> BYPASS.
    ir_scan(5'b11111, ibits, inow);
    check("ir_capture_stream", 64'(ibits), 64'b00001);
    check("ir_all_ones", 64'(inow), 64'h1f);
    dr_scan(64'b1101, 4, 0, 0, dbits, pv, pd);
    check("bypass_stream", dbits[3:0], 64'b1010);
    check("bypass_no_pulse", 64'(pv), 64'd0);

    // User DR 1, straight and with a pause in the middle.
    for (int p = 0; p < 2; p++) begin
      ir_scan(5'h11, ibits, inow);
      check("ir_user1", 64'(inow), 64'h11);
      cap_data = {32'hDEAD_BEEF, 32'($urandom)};
      dr_scan(64'hA5A5_0F0F, 32, 16, p * 10, dbits, pv, pd);
      check("user1_capture", dbits[31:0], 64'hDEAD_BEEF);
      check("user1_pulse", 64'(pv), 64'b10);
      check("user1_data", 64'(pd), 64'hA5A5_0F0F);
      step(1'b0, 1'b0);
      check("user1_pulse_end", 64'(o_valid), 64'd0);
    end

    // Reset in the middle of a user-DR shift.
    ir_scan(5'h11, ibits, inow);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int k = 0; k < 16; k++) step(1'b0, 1'($urandom));
    apply_reset();
    repeat (3) begin
      step(1'b1, 1'b0);
      check("abort_no_pulse", 64'(o_valid), 64'd0);
    end
    check("abort_ir", 64'(o_ir), 64'(IDIR));
    step(1'b0, 1'b0);

    // Randomized scans against the model.
    for (int t = 0; t < 60; t++) begin
      logic [IRW-1:0] code;
      int n;
      case ($urandom_range(0, 4))
        0: code = IDIR;
        1: code = 5'h10;
        2: code = 5'h11;
        3: code = 5'h1f;
        default: code = IRW'($urandom);
      endcase
      ir_scan(code, ibits, inow);
      check("rand_ir_capture", 64'(ibits), 64'b00001);
      cap_data = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      n = $urandom_range(0, 40);
      if ($urandom_range(0, 9) == 0) begin
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        repeat ($urandom_range(1, 20)) step(1'b0, 1'($urandom));
        apply_reset();
      end else begin
        dr_scan(rdata, n, $urandom_range(1, 20), $urandom_range(0, 3), dbits, pv, pd);
      end
      repeat ($urandom_range(0, 8)) step(1'($urandom), 1'($urandom));
      repeat (5) step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
